// File: rtl/dvsd_8216_m3_pkg.sv
// Shared widths, latency and partial-product helper for the dvsd_8216_m3 multiplier.
// LATENCY follows the DVSD_8216_M3_PIPE_EN build macro.
package dvsd_8216_m3_pkg;

   localparam int OP_W   = 8;
   localparam int PROD_W = 16;

`ifdef DVSD_8216_M3_PIPE_EN
   localparam int LATENCY = 2;
`else
   localparam int LATENCY = 1;
`endif

   typedef logic [OP_W-1:0]   op_t;
   typedef logic [PROD_W-1:0] prod_t;

   // One partial-product row: the multiplicand shifted into place when the multiplier bit is set.
   function automatic prod_t pp_row(input op_t op, input logic sel, input int unsigned sh);
      prod_t row;
      row = sel ? (prod_t'(op) << sh) : '0;
      return row;
   endfunction

endpackage

// File: rtl/dvsd_8216_m3_csa_row.sv
// One 16-bit carry-save row: three addends in, a sum/carry pair out.
// The carry vector is already shifted into its weight; the top carry bit is dropped.
module dvsd_8216_m3_csa_row
   import dvsd_8216_m3_pkg::*;
(
   input  logic [15:0] x_i,
   input  logic [15:0] y_i,
   input  logic [15:0] z_i,
   output logic [15:0] sum_o,
   output logic [15:0] carry_o
);

   assign sum_o = x_i ^ y_i ^ z_i;

   // Dropping the majority out of bit 15 is exact: every product fits in 16 bits.
   assign carry_o = {(x_i[14:0] & y_i[14:0]) |
                     (x_i[14:0] & z_i[14:0]) |
                     (y_i[14:0] & z_i[14:0]), 1'b0};

endmodule

// File: rtl/dvsd_8216_m3.sv
// Unsigned 8x8 -> 16 shift-and-add array multiplier with a registered product.
// Build macro DVSD_8216_M3_PIPE_EN adds a stage after rows 0-3 (latency 2 instead of 1).
module dvsd_8216_m3
   import dvsd_8216_m3_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] m
);

   // ---------------- Front half: rows 0-3 reduced to a carry-save pair ----------------
   prod_t pp_lo [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pp_lo[i] = pp_row(a, b[i], i);
      end
   end

   prod_t s0, c0, s1, c1;

   dvsd_8216_m3_csa_row u_csa0 (
      .x_i     (pp_lo[0]),
      .y_i     (pp_lo[1]),
      .z_i     (pp_lo[2]),
      .sum_o   (s0),
      .carry_o (c0)
   );

   dvsd_8216_m3_csa_row u_csa1 (
      .x_i     (s0),
      .y_i     (c0),
      .z_i     (pp_lo[3]),
      .sum_o   (s1),
      .carry_o (c1)
   );

   // ---------------- Optional pipeline stage ----------------
   prod_t      mid_s, mid_c;
   op_t        a_hi;
   logic [3:0] b_hi;

`ifdef DVSD_8216_M3_PIPE_EN
   prod_t      mid_s_q, mid_c_q;
   op_t        a_q;
   logic [3:0] b_hi_q;

   // NOTE: datapath stage registers are reset too, so a product in flight during reset never reaches m.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         mid_s_q <= '0;
         mid_c_q <= '0;
         a_q     <= '0;
         b_hi_q  <= '0;
      end else begin
         mid_s_q <= s1;
         mid_c_q <= c1;
         a_q     <= a;
         b_hi_q  <= b[7:4];
      end
   end

   assign mid_s = mid_s_q;
   assign mid_c = mid_c_q;
   assign a_hi  = a_q;
   assign b_hi  = b_hi_q;
`else
   assign mid_s = s1;
   assign mid_c = c1;
   assign a_hi  = a;
   assign b_hi  = b[7:4];
`endif

   // ---------------- Back half: rows 4-7 folded into the pair ----------------
   prod_t pp_hi [4];

   always_comb begin
      for (int j = 0; j < 4; j++) begin
         pp_hi[j] = pp_row(a_hi, b_hi[j], j + 4);
      end
   end

   prod_t s2, c2, s3, c3, s4, c4, s5, c5;

   dvsd_8216_m3_csa_row u_csa2 (
      .x_i     (mid_s),
      .y_i     (mid_c),
      .z_i     (pp_hi[0]),
      .sum_o   (s2),
      .carry_o (c2)
   );

   dvsd_8216_m3_csa_row u_csa3 (
      .x_i     (s2),
      .y_i     (c2),
      .z_i     (pp_hi[1]),
      .sum_o   (s3),
      .carry_o (c3)
   );

   dvsd_8216_m3_csa_row u_csa4 (
      .x_i     (s3),
      .y_i     (c3),
      .z_i     (pp_hi[2]),
      .sum_o   (s4),
      .carry_o (c4)
   );

   dvsd_8216_m3_csa_row u_csa5 (
      .x_i     (s4),
      .y_i     (c4),
      .z_i     (pp_hi[3]),
      .sum_o   (s5),
      .carry_o (c5)
   );

   // ---------------- Final ripple carry-propagate adder ----------------
   prod_t m_d;
   logic  rca_c;

   // NOTE: the ripple carry is a blocking chain inside one always_comb; default assigned first so no latch.
   always_comb begin
      m_d   = '0;
      rca_c = 1'b0;
      for (int k = 0; k < PROD_W; k++) begin
         m_d[k] = s5[k] ^ c5[k] ^ rca_c;
         rca_c  = (s5[k] & c5[k]) | (rca_c & (s5[k] ^ c5[k]));
      end
   end

   // ---------------- Output register ----------------
   prod_t m_q;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         m_q <= '0;
      end else begin
         m_q <= m_d;
      end
   end

   assign m = m_q;

endmodule

// File: tb/tb_dvsd_8216_m3.sv
// Scoreboard bench for dvsd_8216_m3: directed corners plus a 1000-pair random stream
// with a mid-stream reset, checked against a history-based model using plain arithmetic.
module tb_dvsd_8216_m3;
   import dvsd_8216_m3_pkg::*;

   logic        clock;
   logic        reset_n;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [15:0] m;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   prod_t exp_q [$];
   string tag_q [$];

   // Per-edge stimulus history: was reset asserted, and the true product sampled.
   bit    rst_h  [$];
   prod_t prod_h [$];

   dvsd_8216_m3 dut (
      .clock   (clock),
      .reset_n (reset_n),
      .a       (a),
      .b       (b),
      .m       (m)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Expected m after edge n: zero if any reset occurred in the last LATENCY edges,
   // otherwise the product of the operands sampled LATENCY-1 edges earlier.
   task automatic drive(input logic rst_n_v, input logic [7:0] av, input logic [7:0] bv,
                        input string tag);
      int    n;
      bit    hit;
      prod_t e;
      @(negedge clock);
      reset_n = rst_n_v;
      a       = av;
      b       = bv;
      rst_h.push_back(!rst_n_v);
      prod_h.push_back(prod_t'(int'(av) * int'(bv)));
      n   = rst_h.size() - 1;
      hit = 1'b0;
      for (int k = n - LATENCY + 1; k <= n; k++) begin
         if (k < 0 || rst_h[k]) hit = 1'b1;
      end
      e = hit ? prod_t'(0) : prod_h[n - LATENCY + 1];
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Monitor: the DUT presents a product every cycle.
   initial begin
      prod_t e;
      string t;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk_cnt++;
            if (m === e) pass_cnt++;
            else $display("FAIL %s: m=%h expected=%h at t=%0t", t, m, e, $time);
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      a       = 8'hFF;
      b       = 8'hFF;

      drive(1'b0, 8'hFF, 8'hFF, "reset_hold");
      drive(1'b0, 8'hFF, 8'hFF, "reset_hold");
      drive(1'b1, 8'hFF, 8'hFF, "reset_release_ff_ff");
      drive(1'b1, 8'hFF, 8'hFF, "reset_release_ff_ff");

      drive(1'b1, 8'h00, 8'h00, "zero_zero");
      drive(1'b1, 8'h00, 8'hA5, "zero_a5");
      drive(1'b1, 8'hFF, 8'hFF, "max_max");
      drive(1'b1, 8'h01, 8'hFF, "one_ff");
      drive(1'b1, 8'd150, 8'd150, "mid_150_150");
      drive(1'b1, 8'h80, 8'h80, "msb_msb");

      for (int i = 0; i < 1000; i++) begin
         if (i == 500) drive(1'b0, 8'($urandom), 8'($urandom), "midstream_reset");
         else          drive(1'b1, 8'($urandom), 8'($urandom), "random_stream");
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
      #2;
      chk_cnt++;
      if (exp_q.size() == 0) pass_cnt++;
      else $display("FAIL drain: pending=%0d required=0", exp_q.size());

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
